// File: rtl/riscv_defs_pkg.sv
// Shared RV32I definitions: base opcodes and register-number width.
package riscv_defs_pkg;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_ARITHI = 7'b0010011;
  localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;
endpackage

// File: rtl/rv32i_imm_decode.sv
// Combinational RV32I immediate extraction with illegal-opcode detection.
module rv32i_imm_decode
  import riscv_defs_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 32
) (
  input  logic [INST_WIDTH-1:0] inst,
  output logic [IMM_WIDTH-1:0]  imm,
  output logic                  illegal
);
  logic        [31:0] i;
  logic signed [31:0] imm32;

  assign i = inst[31:0];

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (i[6:0])
      OPCODE_LUI, OPCODE_AUIPC: imm32 = {i[31:12], 12'b0};
      OPCODE_JAL:    imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      OPCODE_JALR, OPCODE_LOAD, OPCODE_ARITHI:
                     imm32 = {{20{i[31]}}, i[31:20]};
      OPCODE_BRANCH: imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPCODE_STORE:  imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      OPCODE_ARITH:  imm32 = '0;
      default:       illegal = 1'b1;
    endcase
  end

  // Signed cast sign-extends when IMM_WIDTH exceeds 32.
  assign imm = IMM_WIDTH'(imm32);
endmodule

// File: rtl/decoded_inst_queue.sv
// Circular FIFO of RV32I instructions decoded at enqueue, with flush and occupancy count.
module decoded_inst_queue
  import riscv_defs_pkg::*;
#(
  parameter int unsigned INST_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 17,
  parameter int unsigned IMM_WIDTH        = 32,
  parameter int unsigned QUEUE_ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           flush,
  input  logic                           enq_valid,
  input  logic [ADDR_WIDTH+INST_WIDTH-1:0] enq_entry,
  output logic                           enq_ready,
  output logic                           deq_valid,
  input  logic                           deq_ready,
  output logic [ADDR_WIDTH-1:0]          deq_addr,
  output logic [6:0]                     deq_opcode,
  output logic [2:0]                     deq_funct3,
  output logic                           deq_funct7b5,
  output logic [REG_W-1:0]               deq_rs1,
  output logic [REG_W-1:0]               deq_rs2,
  output logic [REG_W-1:0]               deq_rd,
  output logic [IMM_WIDTH-1:0]           deq_imm,
  output logic                           deq_illegal,
  output logic [QUEUE_ADDR_WIDTH:0]      count
);
  localparam int unsigned DEPTH = 1 << QUEUE_ADDR_WIDTH;
  localparam logic [QUEUE_ADDR_WIDTH:0] FULL_CNT = {1'b1, {QUEUE_ADDR_WIDTH{1'b0}}};

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [REG_W-1:0]      rs1;
    logic [REG_W-1:0]      rs2;
    logic [REG_W-1:0]      rd;
    logic [IMM_WIDTH-1:0]  imm;
    logic                  illegal;
  } entry_t;

  entry_t                      slots [DEPTH];
  entry_t                      dec;
  entry_t                      head_e;
  logic [QUEUE_ADDR_WIDTH-1:0] head;
  logic [QUEUE_ADDR_WIDTH-1:0] tail;
  logic [INST_WIDTH-1:0]       inst;
  logic [IMM_WIDTH-1:0]        dec_imm;
  logic                        dec_illegal;
  logic                        enq_fire;
  logic                        deq_fire;

  assign inst = enq_entry[INST_WIDTH-1:0];

  rv32i_imm_decode #(
    .INST_WIDTH (INST_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH)
  ) u_imm (
    .inst    (inst),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec          = '0;
    dec.addr     = enq_entry[ADDR_WIDTH+INST_WIDTH-1:INST_WIDTH];
    dec.opcode   = inst[6:0];
    dec.funct3   = inst[14:12];
    dec.funct7b5 = inst[30];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rd       = inst[11:7];
    dec.imm      = dec_imm;
    dec.illegal  = dec_illegal;
  end

  // Full/empty come from count alone; no enqueue when full even if dequeuing.
  assign enq_ready = (count != FULL_CNT);
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq_fire) begin
          slots[tail] <= dec;
          tail        <= tail + 1'b1;
        end
        if (deq_fire) head <= head + 1'b1;
        case ({enq_fire, deq_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign head_e       = slots[head];
  assign deq_addr     = head_e.addr;
  assign deq_opcode   = head_e.opcode;
  assign deq_funct3   = head_e.funct3;
  assign deq_funct7b5 = head_e.funct7b5;
  assign deq_rs1      = head_e.rs1;
  assign deq_rs2      = head_e.rs2;
  assign deq_rd       = head_e.rd;
  assign deq_imm      = head_e.imm;
  assign deq_illegal  = head_e.illegal;
endmodule

// File: tb/tb_decoded_inst_queue.sv
// Scoreboard bench for decoded_inst_queue: expected decodes queued on enqueue, compared at dequeue.
module tb_decoded_inst_queue;
  logic        clk = 1'b0;
  logic        rst, rdy, flush, enq_valid, deq_ready;
  logic [48:0] enq_entry;
  logic        enq_ready, deq_valid, deq_funct7b5, deq_illegal;
  logic [16:0] deq_addr;
  logic [6:0]  deq_opcode;
  logic [2:0]  deq_funct3;
  logic [4:0]  deq_rs1, deq_rs2, deq_rd;
  logic [31:0] deq_imm;
  logic [4:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [16:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] inst_tab [10] = '{
    32'h123450B7, 32'h80000117, 32'hFFDFF0EF, 32'h00C28067, 32'h8000A183,
    32'hFE112E23, 32'h40B50533, 32'h00B50663, 32'h0000007F, 32'hFFF00093
  };

  always #5 clk = ~clk;

  decoded_inst_queue #(
    .INST_WIDTH       (32),
    .ADDR_WIDTH       (17),
    .IMM_WIDTH        (32),
    .QUEUE_ADDR_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_entry    (enq_entry),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_ready    (deq_ready),
    .deq_addr     (deq_addr),
    .deq_opcode   (deq_opcode),
    .deq_funct3   (deq_funct3),
    .deq_funct7b5 (deq_funct7b5),
    .deq_rs1      (deq_rs1),
    .deq_rs2      (deq_rs2),
    .deq_rd       (deq_rd),
    .deq_imm      (deq_imm),
    .deq_illegal  (deq_illegal),
    .count        (count)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [16:0] pc, input logic [31:0] inst);
    exp_t e;
    e     = '0;
    e.pc  = pc;
    e.op  = inst[6:0];
    e.f3  = inst[14:12];
    e.f7  = inst[30];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.rd  = inst[11:7];
    case (inst[6:0])
      7'b0110111, 7'b0010111: e.imm = {inst[31:12], 12'h000};
      7'b1101111: e.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      7'b1100111, 7'b0000011, 7'b0010011: e.imm = {{20{inst[31]}}, inst[31:20]};
      7'b1100011: e.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b0100011: e.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'b0110011: e.imm = 32'h0;
      default: begin e.imm = 32'h0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // Check outputs against the model, then advance the model with the edge.
  task automatic step();
    int   n;
    exp_t h;
    n = exp_q.size();
    check_eq("count", count, n);
    check_eq("enq_ready", enq_ready, n != 16);
    check_eq("deq_valid", deq_valid, n != 0);
    if (n != 0) begin
      h = exp_q[0];
      check_eq("head_pc", deq_addr, h.pc);
      check_eq("head_dec",
               {deq_opcode, deq_funct3, deq_funct7b5, deq_rs1, deq_rs2, deq_rd, deq_imm, deq_illegal},
               {h.op, h.f3, h.f7, h.rs1, h.rs2, h.rd, h.imm, h.ill});
    end
    if (rdy) begin
      if (flush) exp_q.delete();
      else begin
        if (deq_ready && n != 0) void'(exp_q.pop_front());
        if (enq_valid && n != 16) exp_q.push_back(model(enq_entry[48:32], enq_entry[31:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [16:0] pc, input logic [31:0] inst);
    enq_valid = 1'b1;
    enq_entry = {pc, inst};
    step();
    enq_valid = 1'b0;
  endtask

  task automatic drain();
    deq_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    deq_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_entry = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_enq_ready", enq_ready, 1'b1);
    check_eq("rst_deq_valid", deq_valid, 1'b0);
    check_eq("rst_count", count, 5'd0);
    check_eq("rst_fields",
             {deq_addr, deq_opcode, deq_funct3, deq_funct7b5, deq_rs1, deq_rs2, deq_rd, deq_imm, deq_illegal}, '0);
    rst = 1'b1;

    // addi x1,x0,-1 and beq x0,x0,-4
    offer(17'h00100, 32'hFFF00093);
    check_eq("addi_imm", deq_imm, 32'hFFFFFFFF);
    check_eq("addi_rd", deq_rd, 5'd1);
    check_eq("addi_rs1", deq_rs1, 5'd0);
    check_eq("addi_op", deq_opcode, 7'b0010011);
    check_eq("addi_pc", deq_addr, 17'h00100);
    drain();
    offer(17'h00104, 32'hFE000EE3);
    check_eq("beq_imm", deq_imm, 32'hFFFFFFFC);
    drain();

    // Fill to 16, 17th offer dropped, then drain in order
    for (int i = 0; i < 17; i++) offer(17'h01000 + 17'(4 * i), inst_tab[i % 10]);
    check_eq("full_count", count, 5'd16);
    check_eq("full_enq_ready", enq_ready, 1'b0);
    drain();
    check_eq("empty_count", count, 5'd0);

    // Streaming across pointer wrap, also exercises no same-cycle bypass
    deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) offer(17'h02000 + 17'(4 * i), inst_tab[(i + 3) % 10]);
    drain();

    // Simultaneous enqueue/dequeue at count 5
    for (int i = 0; i < 5; i++) offer(17'h03000 + 17'(4 * i), inst_tab[i]);
    deq_ready = 1'b1;
    offer(17'h03100, inst_tab[6]);
    deq_ready = 1'b0;
    check_eq("simul_count", count, 5'd5);
    check_eq("simul_head", deq_addr, 17'h03004);
    drain();

    // Flush with enq and deq both asserted at count 7
    for (int i = 0; i < 7; i++) offer(17'h04000 + 17'(4 * i), inst_tab[i]);
    flush = 1'b1; deq_ready = 1'b1;
    offer(17'h04100, inst_tab[7]);
    flush = 1'b0; deq_ready = 1'b0;
    check_eq("flush_count", count, 5'd0);
    check_eq("flush_deq_valid", deq_valid, 1'b0);
    offer(17'h04200, inst_tab[2]);
    drain();

    // Freeze, then illegal opcode
    offer(17'h05000, inst_tab[0]);
    offer(17'h05004, inst_tab[1]);
    rdy = 1'b0; deq_ready = 1'b1; enq_valid = 1'b1; enq_entry = {17'h05100, inst_tab[3]};
    repeat (3) step();
    rdy = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0;
    check_eq("freeze_count", count, 5'd2);
    check_eq("freeze_head", deq_addr, 17'h05000);
    drain();
    offer(17'h06000, 32'h0000007F);
    check_eq("illegal_flag", deq_illegal, 1'b1);
    check_eq("illegal_imm", deq_imm, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decoded_inst_queue.md
Name: decoded_inst_queue

Overview:
Parametrised successor to the front-end instruction buffer. It sits between the instruction unit and the scoreboard. It accepts {pc, raw instruction} words, decodes the RV32I fields and the sign-extended immediate at enqueue time, and holds them in a circular FIFO. Unlike its predecessor it has a real dequeue handshake, an occupancy count, a flush for mispredict recovery, and an illegal-opcode flag.

Parameters:
INST_WIDTH, 32, raw instruction width.
ADDR_WIDTH, 17, PC width.
IMM_WIDTH, 32, decoded immediate width.
QUEUE_ADDR_WIDTH, 4, log2 of depth (DEPTH = 2**QUEUE_ADDR_WIDTH, minimum 1).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset.
rdy  in  1  global enable; when low, all state holds.
flush  in  1  discard all entries (branch mispredict).
enq_valid  in  1  instruction unit offers an entry.
enq_entry  in  ADDR_WIDTH+INST_WIDTH  {pc, inst}, inst in the low bits.
enq_ready  out  1  queue can accept an entry this cycle.
deq_valid  out  1  head entry is present.
deq_ready  in  1  scoreboard consumes the head.
deq_addr  out  ADDR_WIDTH  head pc.
deq_opcode  out  7  head opcode.
deq_funct3  out  3  head funct3.
deq_funct7b5  out  1  head inst[30] (SUB/SRA select).
deq_rs1  out  5  head rs1.
deq_rs2  out  5  head rs2.
deq_rd  out  5  head rd.
deq_imm  out  IMM_WIDTH  head immediate.
deq_illegal  out  1  head opcode is not one of the nine supported.
count  out  QUEUE_ADDR_WIDTH+1  occupancy, 0..DEPTH.

Behaviour:
- Storage: per-slot registers; head and tail pointers of QUEUE_ADDR_WIDTH bits that wrap modulo DEPTH; count register.
- Reset (rst==0 at an edge): head=tail=count=0; all slots zeroed. This makes deq_valid=0, enq_ready=1, and every deq_* field 0.
- Priority at each edge: reset, then !rdy (hold everything, ignore all inputs), then flush, then normal operation.
- enq_ready = (count != DEPTH). It is purely registered state: no enqueue when full, even if a dequeue happens in the same cycle.
- deq_valid = (count != 0). The deq_* fields show the slot at head combinationally. Their values are don't-care when deq_valid=0.
- Enqueue fires when enq_valid && enq_ready. The decoded entry is written at tail and tail increments.
- Dequeue fires when deq_valid && deq_ready. Head increments.
- Both fire in one cycle: count is unchanged and both pointers advance.
- Latency: an entry enqueued at edge N is visible at the outputs after edge N. There is no same-cycle enqueue-to-dequeue bypass, even when the queue is empty.
- flush: head=tail=count=0 at the next edge. enq and deq in the same cycle are ignored. Slot contents need not be cleared.
- Field extraction: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], funct3=inst[14:12].
- Immediate is sign-extended from inst[31]:
  - LUI/AUIPC: {inst[31:12],12'b0}.
  - JAL: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - JALR/LOAD/ARITHI: inst[31:20].
  - BRANCH: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - STORE: {inst[31:25],inst[11:7]}.
  - ARITH: 0.
- Any other opcode: imm=0 and illegal=1. The entry is still queued in order.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. count alone distinguishes full from empty.

Decomposition:
- Shared package riscv_defs_pkg holds the OPCODE_* localparams (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ARITHI 0010011, ARITH 0110011) and the register-number width of 5.
- One combinational sub-module, rv32i_imm_decode: input inst, outputs imm and illegal. It is reused later by the decoder.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> enq_ready=1, deq_valid=0, count=0, all deq_* = 0.
- Immediate decode: enqueue pc=0x00100 with inst 0xFFF00093 (addi x1,x0,-1) -> next cycle deq_valid=1, deq_imm=0xFFFFFFFF, rd=1, rs1=0, opcode=0010011, addr=0x00100. Repeat with inst 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC.
- Fill, wrap and backpressure: with deq_ready=0, enqueue 16 entries -> count=16 and enq_ready=0. A 17th offer is dropped. Then dequeue 16 entries -> pcs come out in order and count=0. Enqueue 20 more with deq_ready=1 -> FIFO order holds across the pointer wrap.
- Simultaneous enqueue/dequeue at count=5 -> count stays 5 and the head pc advances by one entry.
- Flush with enq_valid=1 and deq_ready=1 at count=7 -> next cycle count=0 and deq_valid=0. The offered entry is not stored.
- Freeze and illegal: hold rdy=0 for 3 cycles while enq_valid=1 and deq_ready=1 -> no state change. Then enqueue inst 0x0000007F -> deq_illegal=1 and deq_imm=0.
